msk_rnd_source: RTL and testbench



---
 rtl/msk_rnd_pkg.sv | 29 ++
 rtl/msk_rnd_lfsr.sv | 57 +++++
 rtl/msk_rnd_source.sv | 125 ++++++++++++
 tb/tb_msk_rnd_source.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/msk_rnd_pkg.sv
// Shared constants, FSM encoding and the single-step LFSR function for the
// masked-gadget random source. The optional health monitor is enabled with
// MSK_RND_HEALTH_EN; ERR stays in the enum either way.
package msk_rnd_pkg;

  localparam int LFSR_W     = 128;
  localparam int SEED_W     = 32;
  localparam int SEED_BEATS = 4;

  // Tap positions 128,126,101,99 expressed as 0-based bit indices
  localparam int TAP_A = 127;
  localparam int TAP_B = 125;
  localparam int TAP_C = 100;
  localparam int TAP_D = 98;

  typedef enum logic [1:0] {
    SEED = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {s[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/msk_rnd_lfsr.sv
// 128-bit Fibonacci LFSR with a 32-bit shift-load path and an RND_W-step
// unrolled advance. With MSK_RND_HEALTH_EN an all-zero detector is exported.
module msk_rnd_lfsr
  import msk_rnd_pkg::*;
#(
  parameter int RND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [SEED_W-1:0] load_data,
  input  logic              advance,
  input  logic              fix_zero,
`ifdef MSK_RND_HEALTH_EN
  output logic              zero,
`endif
  output logic [RND_W-1:0]  word
);

  logic [LFSR_W-1:0] s;
  logic [LFSR_W-1:0] advanced;
  logic [LFSR_W-1:0] loaded;

  // RND_W single steps chained so one clock yields RND_W fresh bits
  always_comb begin
    advanced = s;
    for (int i = 0; i < RND_W; i++) begin
      advanced = lfsr_step(advanced);
    end
  end

  // Seed chunk shifts in at the bottom; an all-zero final seed would lock up
  always_comb begin
    loaded = {s[LFSR_W-SEED_W-1:0], load_data};
    if (fix_zero && (loaded == '0)) begin
      loaded[0] = 1'b1;
    end
  end

  // State register: load has priority, otherwise advance when asked
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
    end else if (load) begin
      s <= loaded;
    end else if (advance) begin
      s <= advanced;
    end
  end

  assign word = s[RND_W-1:0];

`ifdef MSK_RND_HEALTH_EN
  assign zero = (s == '0);
`endif

endmodule

// File: rtl/msk_rnd_source.sv
// Random-bit producer for masked gadgets: seed load over valid/ready, LFSR
// warm-up, then RND_W bits per enabled cycle. Optional health monitor via
// MSK_RND_HEALTH_EN (sticky ERR on an all-zero LFSR state).
//
// state | meaning
// SEED  | collecting 4 seed beats
// WARM  | advancing WARMUP times before output is trusted
// RUN   | streaming, advance on rnd_en
// ERR   | health fault, left by rst or reseed (health build only)
module msk_rnd_source
  import msk_rnd_pkg::*;
#(
  parameter int d      = 2,
  parameter int RND_W  = d * (d - 1),
  parameter int WARMUP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEED_W-1:0] seed_in,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              reseed,
  input  logic              rnd_en,
  output logic [RND_W-1:0]  rnd,
  output logic              rnd_valid,
  output logic              busy,
  output logic              err
);

  if (RND_W > 64 || RND_W < 1) begin : g_bad_rnd_w
    $error("msk_rnd_source: RND_W must be within 1..64");
  end
  if (WARMUP < 1) begin : g_bad_warmup
    $error("msk_rnd_source: WARMUP must be at least 1");
  end

  localparam int CW = $clog2(WARMUP + 1);

  state_t            state, state_nxt;
  logic [1:0]        beat_cnt;
  logic [CW-1:0]     warm_cnt;
  logic              beat_accept;
  logic              last_beat;
  logic              advance;
  logic [RND_W-1:0]  word;
`ifdef MSK_RND_HEALTH_EN
  logic              zero;
`endif

  assign beat_accept = seed_valid & seed_ready;
  assign last_beat   = beat_accept & (beat_cnt == 2'(SEED_BEATS - 1));
  assign advance     = ~reseed & ((state == WARM) | ((state == RUN) & rnd_en));

  msk_rnd_lfsr #(.RND_W(RND_W)) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (beat_accept),
    .load_data (seed_in),
    .advance   (advance),
    .fix_zero  (last_beat),
`ifdef MSK_RND_HEALTH_EN
    .zero      (zero),
`endif
    .word      (word)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= SEED;
    else     state <= state_nxt;
  end

  // FSM next-state logic; reseed wins over every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      SEED: if (last_beat) state_nxt = WARM;
      WARM: begin
        if (reseed)                    state_nxt = SEED;
        else if (warm_cnt == CW'(1))   state_nxt = RUN;
      end
      RUN:  if (reseed) state_nxt = SEED;
`ifdef MSK_RND_HEALTH_EN
      ERR:  if (reseed) state_nxt = SEED;
`else
      ERR:  state_nxt = SEED;
`endif
      default: state_nxt = SEED;
    endcase
`ifdef MSK_RND_HEALTH_EN
    if ((state == WARM || state == RUN) && zero && !reseed) begin
      state_nxt = ERR;
    end
`endif
  end

  // Beat counter restarts on reseed; warm counter loads on the 4th beat
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      warm_cnt <= '0;
    end else begin
      if (reseed)           beat_cnt <= '0;
      else if (last_beat)   beat_cnt <= '0;
      else if (beat_accept) beat_cnt <= beat_cnt + 2'd1;

      if (last_beat)                             warm_cnt <= CW'(WARMUP);
      else if (state == WARM && warm_cnt != '0)  warm_cnt <= warm_cnt - CW'(1);
    end
  end

  // FSM outputs and gating of the random word
  always_comb begin
    rnd_valid  = (state == RUN);
    rnd        = rnd_valid ? word : '0;
    busy       = (state != RUN);
    seed_ready = (state == SEED) & ~reseed;
`ifdef MSK_RND_HEALTH_EN
    err        = (state == ERR);
`else
    err        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_msk_rnd_source.sv
// Scoreboard bench for msk_rnd_source: stimulus pushes expected words from a
// bit-stream LFSR model, a negedge monitor compares whenever rnd_valid is up.
module tb_msk_rnd_source;

  localparam int RND_W  = 2;
  localparam int WARMUP = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      seed_in = '0;
  logic             seed_valid = 1'b0;
  logic             seed_ready;
  logic             reseed = 1'b0;
  logic             rnd_en = 1'b0;
  logic [RND_W-1:0] rnd;
  logic             rnd_valid;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;
  bit mon_off = 1'b0;

  logic [127:0]     m;
  logic [RND_W-1:0] q[$];

  always #5 clk = ~clk;

  msk_rnd_source #(.d(2), .RND_W(RND_W), .WARMUP(WARMUP)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_in    (seed_in),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .reseed     (reseed),
    .rnd_en     (rnd_en),
    .rnd        (rnd),
    .rnd_valid  (rnd_valid),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the register is a bit history; each new bit is the XOR of the
  // bits 128, 126, 101 and 99 positions back. RND_W new bits per advance.
  function automatic logic [127:0] model_adv(input logic [127:0] s);
    logic [127:0] r;
    r = s;
    for (int i = 0; i < RND_W; i++) r = {r[126:0], r[127] ^ r[125] ^ r[100] ^ r[98]};
    return r;
  endfunction

  // Monitor: every valid cycle checks the front word; consumption pops it
  always @(negedge clk) begin
    if (!rst && !mon_off) begin
      if (rnd_valid) begin
        if (q.size() == 0) chk("scb_empty", 1, 0);
        else begin
          chk("rnd_word", rnd, q[0]);
          if (rnd_en) void'(q.pop_front());
        end
      end else begin
        chk("rnd_gated", rnd, 0);
      end
`ifndef MSK_RND_HEALTH_EN
      chk("err_tied", err, 0);
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_beats(input logic [31:0] b0, b1, b2, b3);
    logic [31:0] b[4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seed_valid = 1'b1;
      seed_in    = b[i];
      @(negedge clk);
      chk("seed_ready_beat", seed_ready, 1);
      m = {m[95:0], b[i]};
    end
    @(posedge clk); #1;
    seed_valid = 1'b0;
    if (m == '0) m[0] = 1'b1;
  endtask

  task automatic wait_warm();
    for (int i = 0; i < WARMUP; i++) m = model_adv(m);
    q.push_back(m[RND_W-1:0]);
    for (int k = 0; k <= WARMUP; k++) begin
      if (k > 0) @(posedge clk);
      #1 rnd_en = (k < WARMUP) ? 1'($urandom) : 1'b0;
      @(negedge clk);
      chk("valid_rise", rnd_valid, (k == WARMUP));
      chk("busy_warm", busy, (k != WARMUP));
    end
  endtask

  task automatic stream(input int n, input int pct);
    bit en;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      en = ($urandom_range(99) < pct);
      rnd_en = en;
      if (en) begin
        m = model_adv(m);
        q.push_back(m[RND_W-1:0]);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rnd_en = 1'b0; seed_valid = 1'b0; reseed = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m = '0;
    @(negedge clk);
    chk("rst_valid", rnd_valid, 0);
    chk("rst_rnd", rnd, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", err, 0);
    chk("rst_seed_ready", seed_ready, 1);
  endtask

  initial begin
    logic [RND_W-1:0] held;
    m = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", rnd_valid, 0);
    chk("rst_rnd", rnd, 0);
    chk("rst_busy", busy, 1);
    chk("rst_err", err, 0);
    chk("rst_seed_ready", seed_ready, 1);

    // Known seed, 1000 consecutive words, then random enables
    load_beats(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F);
    wait_warm();
    stream(1000, 100);
    stream(300, 60);

    // Hold for 5 cycles then resume
    @(posedge clk); #1 rnd_en = 1'b0;
    @(negedge clk);
    held = rnd;
    chk("hold_model", held, m[RND_W-1:0]);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_const", rnd, held);
    end
    stream(50, 100);

    // Reseed in RUN with a coincident beat that must be dropped
    @(posedge clk); #1;
    rnd_en = 1'b0; reseed = 1'b1; seed_valid = 1'b1; seed_in = $urandom;
    @(negedge clk);
    chk("reseed_blocks_ready", seed_ready, 0);
    @(posedge clk); #1;
    reseed = 1'b0; seed_valid = 1'b0;
    q.delete();
    @(negedge clk);
    chk("reseed_valid", rnd_valid, 0);
    chk("reseed_rnd", rnd, 0);
    chk("reseed_ready", seed_ready, 1);
    chk("reseed_busy", busy, 1);
    load_beats($urandom, $urandom, $urandom, $urandom);
    wait_warm();
    stream(200, 70);

    // Reset 7 cycles into WARM, then a full reload
    do_reset();
    load_beats($urandom, $urandom, $urandom, $urandom);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("warm_rst_valid", rnd_valid, 0);
    chk("warm_rst_ready", seed_ready, 1);
    chk("warm_rst_busy", busy, 1);
    m = '0;
    load_beats($urandom, $urandom, $urandom, $urandom);
    wait_warm();
    stream(100, 80);

    // All-zero seed must be nudged to 1
    do_reset();
    load_beats(32'h0, 32'h0, 32'h0, 32'h0);
    chk("zero_fix_model", m, 128'h1);
    wait_warm();
    stream(200, 100);

`ifdef MSK_RND_HEALTH_EN
    @(posedge clk); #1;
    rnd_en = 1'b0; mon_off = 1'b1;
    force dut.u_lfsr.s = '0;
    @(posedge clk); #1;
    release dut.u_lfsr.s;
    @(negedge clk);
    chk("health_err", err, 1);
    chk("health_valid", rnd_valid, 0);
    chk("health_ready", seed_ready, 0);
    q.delete();
    @(posedge clk); #1 reseed = 1'b1;
    @(posedge clk); #1 reseed = 1'b0;
    @(negedge clk);
    chk("health_clear", err, 0);
    chk("health_ready_back", seed_ready, 1);
    mon_off = 1'b0;
    load_beats($urandom, $urandom, $urandom, $urandom);
    wait_warm();
    stream(50, 100);
`endif

    @(posedge clk); #1 rnd_en = 1'b0;
    @(negedge clk);
    chk("scb_drain", q.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
